vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_VISIBLE, default 800, active pixels per line.
REQ-002 Parameter H_SYNC_START, default 840, first hcount with hsync asserted.
REQ-003 Parameter H_SYNC_END, default 968, first hcount after hsync deasserts.
REQ-004 Parameter H_TOTAL, default 1056, pixels per line including blanking.
REQ-005 Parameter V_VISIBLE, default 600, active lines per frame.
REQ-006 Parameter V_SYNC_START, default 601, first vcount with vsync asserted.
REQ-007 Parameter V_SYNC_END, default 605, first vcount after vsync deasserts.
REQ-008 Parameter V_TOTAL, default 628, lines per frame including blanking.
REQ-009 Port clk, input, 1, pixel clock (40 MHz for the defaults); one clock, all logic on its rising edge.
REQ-010 Port rst, input, 1, asynchronous active-high reset.
REQ-011 Port vcount, output, 11, current line number.
REQ-012 Port vsync, output, 1, vertical sync, active high.
REQ-013 Port vblnk, output, 1, vertical blanking flag.
REQ-014 Port hcount, output, 11, current pixel number within the line.
REQ-015 Port hsync, output, 1, horizontal sync, active high.
REQ-016 Port hblnk, output, 1, horizontal blanking flag.
REQ-017 Port frame_start, output, 1, one-cycle frame-boundary pulse (see Configuration).

Function
REQ-018 All outputs SHALL be driven directly from flip-flops, with no combinational path from counters to ports.
REQ-019 hcount SHALL increment by 1 every clk cycle and wrap from H_TOTAL-1 to 0.
REQ-020 vcount SHALL increment by 1 in the same cycle that hcount wraps, and hold otherwise.
REQ-021 vcount SHALL wrap from V_TOTAL-1 to 0 when hcount also wraps.
REQ-022 hblnk SHALL be 1 exactly when the presented hcount >= H_VISIBLE, with no skew relative to hcount.
REQ-023 hsync SHALL be 1 exactly when H_SYNC_START <= presented hcount < H_SYNC_END.
REQ-024 vblnk SHALL be 1 exactly when presented vcount >= V_VISIBLE, for every hcount on those lines.
REQ-025 vsync SHALL be 1 exactly when V_SYNC_START <= presented vcount < V_SYNC_END.
REQ-026 The flags SHALL therefore be computed from next-state counter values and registered together with the counters.
REQ-027 All comparisons SHALL be unsigned, 11-bit, with parameters required to satisfy VISIBLE < SYNC_START < SYNC_END <= TOTAL <= 2048.
REQ-028 hcount SHALL never present a value >= H_TOTAL, and vcount SHALL never present a value >= V_TOTAL.

Reset
REQ-029 While rst=1, hcount and vcount SHALL be 0 and hsync, vsync, hblnk, vblnk and frame_start SHALL be 0, asynchronously.
REQ-030 After rst is released, the first rising edge SHALL present hcount=1 and vcount=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately, without completing the line or frame.

Configuration
REQ-032 With macro VGA_FRAME_START_EN defined, frame_start SHALL be 1 for exactly one cycle when the outputs present hcount=0 and vcount=0, arriving from the wrap at (H_TOTAL-1, V_TOTAL-1).
REQ-033 Under VGA_FRAME_START_EN, the (0,0) state held during and immediately after reset SHALL NOT pulse frame_start.
REQ-034 Without VGA_FRAME_START_EN, frame_start SHALL be tied to constant 0 and its logic SHALL not be synthesised.

Verification
REQ-035 Release reset, run 1056 cycles -> hcount sequence 1..1055, 0, and vcount steps 0 to 1 on the cycle hcount shows 0.
REQ-036 Line 0 check -> hblnk=1 for hcount 800..1055, hsync=1 for hcount 840..967, both 0 for all other hcount values.
REQ-037 Run a full frame of 1056*628 = 663168 cycles -> vblnk=1 for vcount 600..627, vsync=1 for vcount 601..604, and vcount wraps 627 to 0 together with hcount wrapping 1055 to 0.
REQ-038 With VGA_FRAME_START_EN defined, run 2 frames after reset -> exactly 2 frame_start pulses, 663168 cycles apart, none at reset release; without the macro, frame_start stays 0 throughout.
REQ-039 Assert rst asynchronously (between clk edges) at hcount=500, vcount=300 -> all outputs 0 immediately; after release, the counters restart per REQ-030.
REQ-040 Cover the whole frame -> at no cycle is hcount > 1055 or vcount > 627, and the flags always match REQ-022 to REQ-025 for the presented counters.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with registered sync and blanking flags.
// Optional one-cycle frame_start pulse is built when VGA_FRAME_START_EN is defined.
module vga_timing #(
  parameter int H_VISIBLE    = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_END   = 968,
  parameter int H_TOTAL      = 1056,
  parameter int V_VISIBLE    = 600,
  parameter int V_SYNC_START = 601,
  parameter int V_SYNC_END   = 605,
  parameter int V_TOTAL      = 628
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic        frame_start
);

  // 12-bit constants so a bound of 2048 still compares correctly
  localparam logic [11:0] HV  = 12'(H_VISIBLE);
  localparam logic [11:0] HSS = 12'(H_SYNC_START);
  localparam logic [11:0] HSE = 12'(H_SYNC_END);
  localparam logic [11:0] HT  = 12'(H_TOTAL);
  localparam logic [11:0] VV  = 12'(V_VISIBLE);
  localparam logic [11:0] VSS = 12'(V_SYNC_START);
  localparam logic [11:0] VSE = 12'(V_SYNC_END);
  localparam logic [11:0] VT  = 12'(V_TOTAL);

  logic        h_last;
  logic        v_last;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic        hs_nxt;
  logic        hb_nxt;
  logic        vs_nxt;
  logic        vb_nxt;

  always_comb begin
    h_last = ({1'b0, hcount} == HT - 12'd1);
    v_last = ({1'b0, vcount} == VT - 12'd1);
    h_nxt  = h_last ? 11'd0 : hcount + 11'd1;
    v_nxt  = vcount;
    if (h_last) begin
      v_nxt = v_last ? 11'd0 : vcount + 11'd1;
    end
  end

  // flags look at the counter values about to be presented
  always_comb begin
    h_ext  = {1'b0, h_nxt};
    v_ext  = {1'b0, v_nxt};
    hb_nxt = (h_ext >= HV);
    hs_nxt = (h_ext >= HSS) && (h_ext < HSE);
    vb_nxt = (v_ext >= VV);
    vs_nxt = (v_ext >= VSS) && (v_ext < VSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      hsync  <= 1'b0;
      hblnk  <= 1'b0;
      vsync  <= 1'b0;
      vblnk  <= 1'b0;
    end else begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      hsync  <= hs_nxt;
      hblnk  <= hb_nxt;
      vsync  <= vs_nxt;
      vblnk  <= vb_nxt;
    end
  end

`ifdef VGA_FRAME_START_EN
  // pulses only on the real wrap, never on the reset-held origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_last && v_last;
    end
  end
`else
  assign frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed vectors plus per-cycle model checks on a default
// instance and a reduced-geometry instance (16x10) covering whole frames.
module tb_vga_timing;

`ifdef VGA_FRAME_START_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] d_vc, d_hc, s_vc, s_hc;
  logic d_vs, d_vb, d_hs, d_hb, d_fs;
  logic s_vs, s_vb, s_hs, s_hb, s_fs;

  always #5 clk = ~clk;

  vga_timing dut (
    .clk(clk), .rst(rst),
    .vcount(d_vc), .vsync(d_vs), .vblnk(d_vb),
    .hcount(d_hc), .hsync(d_hs), .hblnk(d_hb),
    .frame_start(d_fs)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_SYNC_START(10), .H_SYNC_END(13), .H_TOTAL(16),
    .V_VISIBLE(5), .V_SYNC_START(6), .V_SYNC_END(8), .V_TOTAL(10)
  ) dut_s (
    .clk(clk), .rst(rst),
    .vcount(s_vc), .vsync(s_vs), .vblnk(s_vb),
    .hcount(s_hc), .hsync(s_hs), .hblnk(s_hb),
    .frame_start(s_fs)
  );

  typedef struct {
    int n;
    int h;
    int v;
    bit hs;
    bit hb;
    bit vs;
    bit vb;
  } vec_t;

  localparam int NV = 17;
  vec_t tab [NV];

  int checks = 0;
  int errors = 0;
  int n = 0;
  int ti = 0;
  int fs_cnt = 0;

  function automatic logic [31:0] pack(
    input int h, input int v,
    input bit hs, input bit hb, input bit vs, input bit vb, input bit fs);
    logic [10:0] hh;
    logic [10:0] vv;
    hh = 11'(h);
    vv = 11'(v);
    return {5'd0, hh, vv, hs, hb, vs, vb, fs};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] s_act();
    return {5'd0, s_hc, s_vc, s_hs, s_hb, s_vs, s_vb, s_fs};
  endfunction

  function automatic logic [31:0] d_act();
    return {5'd0, d_hc, d_vc, d_hs, d_hb, d_vs, d_vb, d_fs};
  endfunction

  task automatic step();
    int p, eh, ev, dh, dv;
    bit efs;
    @(posedge clk);
    #1;
    n++;
    p   = n % 160;
    eh  = p % 16;
    ev  = p / 16;
    efs = FS_EN && (p == 0);
    if (s_fs) fs_cnt++;
    chk($sformatf("small n=%0d", n), s_act(),
        pack(eh, ev, eh >= 10 && eh < 13, eh >= 8,
             ev >= 6 && ev < 8, ev >= 5, efs));
    if (n <= 1056) begin
      dh = n % 1056;
      dv = n / 1056;
      chk($sformatf("dflt n=%0d", n), d_act(),
          pack(dh, dv, dh >= 840 && dh < 968, dh >= 800, 1'b0, 1'b0, 1'b0));
    end
    if (ti < NV && tab[ti].n == n) begin
      chk($sformatf("vec%0d n=%0d", ti, n),
          {5'd0, s_hc, s_vc, s_hs, s_hb, s_vs, s_vb, 1'b0},
          pack(tab[ti].h, tab[ti].v, tab[ti].hs, tab[ti].hb,
               tab[ti].vs, tab[ti].vb, 1'b0));
      ti++;
    end
  endtask

  initial begin
    tab[0]  = '{1,   1,  0, 0, 0, 0, 0};
    tab[1]  = '{7,   7,  0, 0, 0, 0, 0};
    tab[2]  = '{8,   8,  0, 0, 1, 0, 0};
    tab[3]  = '{9,   9,  0, 0, 1, 0, 0};
    tab[4]  = '{10,  10, 0, 1, 1, 0, 0};
    tab[5]  = '{12,  12, 0, 1, 1, 0, 0};
    tab[6]  = '{13,  13, 0, 0, 1, 0, 0};
    tab[7]  = '{15,  15, 0, 0, 1, 0, 0};
    tab[8]  = '{16,  0,  1, 0, 0, 0, 0};
    tab[9]  = '{80,  0,  5, 0, 0, 0, 1};
    tab[10] = '{95,  15, 5, 0, 1, 0, 1};
    tab[11] = '{96,  0,  6, 0, 0, 1, 1};
    tab[12] = '{127, 15, 7, 0, 1, 1, 1};
    tab[13] = '{128, 0,  8, 0, 0, 0, 1};
    tab[14] = '{159, 15, 9, 0, 1, 0, 1};
    tab[15] = '{160, 0,  0, 0, 0, 0, 0};
    tab[16] = '{161, 1,  0, 0, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset dflt", d_act(), 32'd0);
    chk("reset small", s_act(), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 1056; i++) step();
    chk("fs pulses", 32'(fs_cnt), FS_EN ? 32'd6 : 32'd0);

    // restart and abandon the frame mid-line at small (5,3)
    rst = 1'b1;
    #2;
    rst = 1'b0;
    n = 0;
    fs_cnt = 0;
    for (int i = 0; i < 53; i++) step();
    chk("pre rst pos", {21'd0, s_hc}, 32'd5);
    chk("pre rst line", {21'd0, s_vc}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst small", s_act(), 32'd0);
    chk("async rst dflt", d_act(), 32'd0);
    @(posedge clk);
    #1;
    chk("held rst small", s_act(), 32'd0);
    #3;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 170; i++) step();
    chk("fs after rst", 32'(fs_cnt), FS_EN ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
